// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: control FSM for a multicycle RV32 datapath.
// States IF, ID, EX, MEM, WB, HALT; all controls decoded from state+inputs.
// Ports: clk, reset (async, active high); opcode (IR[6:0]); bcond (EX);
//   halt_cond (ID); mem_ready; datapath controls pc_write, ir_write,
//   i_or_d, mem_read, mem_write, reg_write, mem_to_reg, alu_src_a,
//   alu_src_b, alu_op, pc_source; halted; retired_count.
// Build option: define MEM_WAIT_EN to let IF and MEM stall on mem_ready;
//   otherwise mem_ready is ignored and every memory state takes one cycle.
module multicycle_control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic        bcond,
   input  logic        halt_cond,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        halted,
   output logic [31:0] retired_count
);

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t      state;
   state_t      next_state;
   logic        ready;
   logic        retire;
   logic        is_load;
   logic        is_store;
   logic        is_ecall;
   logic        is_known;
   logic [31:0] count;

`ifdef MEM_WAIT_EN
   assign ready = mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
   assign ready = 1'b1;
`endif

   assign is_load  = (opcode == OP_LOAD);
   assign is_store = (opcode == OP_STORE);
   assign is_ecall = (opcode == OP_ECALL);
   assign is_known = opcode inside {OP_ARITH, OP_ARITH_IMM, OP_LOAD,
                                    OP_STORE, OP_BRANCH, OP_JAL,
                                    OP_JALR, OP_ECALL};

   always_comb begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      halted     = 1'b0;
      next_state = S_IF;
      case (state)
         S_IF: begin
            mem_read   = 1'b1;
            ir_write   = ready;
            next_state = ready ? S_ID : S_IF;
         end
         S_ID: begin
            // ALUOut <= PC + 4, used later as the fall-through PC
            alu_src_b = 2'b01;
            if (is_ecall && halt_cond) begin
               next_state = S_HALT;
            end else if (is_ecall || !is_known) begin
               pc_write   = 1'b1;
               pc_source  = 2'b01;
               next_state = S_IF;
            end else begin
               next_state = S_EX;
            end
         end
         S_EX: begin
            case (opcode)
               OP_ARITH: begin
                  alu_src_a  = 1'b1;
                  alu_op     = 2'b10;
                  next_state = S_WB;
               end
               OP_ARITH_IMM: begin
                  alu_src_a  = 1'b1;
                  alu_src_b  = 2'b10;
                  alu_op     = 2'b10;
                  next_state = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a  = 1'b1;
                  alu_src_b  = 2'b10;
                  next_state = S_MEM;
               end
               OP_BRANCH: begin
                  alu_src_a  = 1'b1;
                  alu_op     = 2'b01;
                  pc_write   = 1'b1;
                  pc_source  = bcond ? 2'b10 : 2'b01;
                  next_state = S_IF;
               end
               OP_JAL: begin
                  // rd <= ALUOut (PC+4 from ID); target from PC+imm adder
                  reg_write  = 1'b1;
                  pc_write   = 1'b1;
                  pc_source  = 2'b10;
                  next_state = S_IF;
               end
               OP_JALR: begin
                  alu_src_a  = 1'b1;
                  alu_src_b  = 2'b10;
                  reg_write  = 1'b1;
                  pc_write   = 1'b1;
                  next_state = S_IF;
               end
               default: next_state = S_IF;
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            mem_read  = is_load;
            mem_write = is_store;
            if (!ready) begin
               next_state = S_MEM;
            end else if (is_load) begin
               next_state = S_WB;
            end else begin
               pc_write   = 1'b1;
               pc_source  = 2'b01;
               next_state = S_IF;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = is_load;
            pc_write   = 1'b1;
            pc_source  = 2'b01;
            next_state = S_IF;
         end
         S_HALT: begin
            halted     = 1'b1;
            next_state = S_HALT;
         end
         default: next_state = S_IF;
      endcase
   end

   // an instruction retires on any edge from a working state back to IF
   assign retire = (next_state == S_IF) &&
                   (state inside {S_ID, S_EX, S_MEM, S_WB});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IF;
         count <= 32'd0;
      end else begin
         state <= next_state;
         if (retire)
            count <= count + 32'd1;
      end
   end

   assign retired_count = count;

endmodule
